// File: rtl/reg_file_2r1w.sv
// Register file with one write port, two registered read ports with write-through bypass,
// and a per-register busy scoreboard. Define RF_ZERO_REG_EN to hardwire register 0 to zero.
module reg_file_2r1w #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WE,
  input  logic [ADDR_W-1:0] WADDR,
  input  logic [WIDTH-1:0]  WDATA,
  input  logic              RE_A,
  input  logic [ADDR_W-1:0] RADDR_A,
  output logic [WIDTH-1:0]  DOUT_A,
  input  logic              RE_B,
  input  logic [ADDR_W-1:0] RADDR_B,
  output logic [WIDTH-1:0]  DOUT_B,
  input  logic              ISSUE,
  input  logic [ADDR_W-1:0] ISSUE_ADDR,
  output logic              BUSY_A,
  output logic              BUSY_B
);

`ifdef RF_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [WIDTH-1:0] sel_a_p0, sel_b_p0;
  logic [WIDTH-1:0] dout_a_p1, dout_b_p1;

  // An address is live when it names a real, writable register.
  function automatic logic addr_live(input logic [ADDR_W-1:0] a);
    addr_live = (int'(a) < DEPTH) && !(ZERO_REG && (a == '0));
  endfunction

  function automatic logic [WIDTH-1:0] read_sel(
    input logic              live,
    input logic              hit,
    input logic [WIDTH-1:0]  wd,
    input logic [WIDTH-1:0]  stored
  );
    if (!live)
      read_sel = '0;
    else if (hit)
      read_sel = wd;
    else
      read_sel = stored;
  endfunction

  function automatic logic busy_sel(
    input logic live,
    input logic hit,
    input logic stored
  );
    busy_sel = live && stored && !hit;
  endfunction

  logic hit_a, hit_b, live_a, live_b;

  assign live_a = addr_live(RADDR_A);
  assign live_b = addr_live(RADDR_B);
  assign hit_a  = WE && (WADDR == RADDR_A);
  assign hit_b  = WE && (WADDR == RADDR_B);

  // Stage p0: address decode and bypass selection
  always_comb begin
    sel_a_p0 = '0;
    sel_b_p0 = '0;
    if (live_a)
      sel_a_p0 = read_sel(1'b1, hit_a, WDATA, mem[RADDR_A]);
    if (live_b)
      sel_b_p0 = read_sel(1'b1, hit_b, WDATA, mem[RADDR_B]);
  end

  always_comb begin
    BUSY_A = 1'b0;
    BUSY_B = 1'b0;
    if (live_a)
      BUSY_A = busy_sel(1'b1, hit_a, busy_q[RADDR_A]);
    if (live_b)
      BUSY_B = busy_sel(1'b1, hit_b, busy_q[RADDR_B]);
  end

  // Issue is applied after writeback so a same-address issue leaves the register busy.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      busy_q <= '0;
    end else begin
      if (WE && addr_live(WADDR)) begin
        mem[WADDR]    <= WDATA;
        busy_q[WADDR] <= 1'b0;
      end
      if (ISSUE && addr_live(ISSUE_ADDR))
        busy_q[ISSUE_ADDR] <= 1'b1;
    end
  end

  // Stage p1: registered read data, held while the port is not enabled
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dout_a_p1 <= '0;
      dout_b_p1 <= '0;
    end else begin
      if (RE_A)
        dout_a_p1 <= sel_a_p0;
      if (RE_B)
        dout_b_p1 <= sel_b_p0;
    end
  end

  assign DOUT_A = dout_a_p1;
  assign DOUT_B = dout_b_p1;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Self-checking bench for reg_file_2r1w (DEPTH=6 to exercise out-of-range addresses):
// directed vector table, reset/zero-register sequences and a randomized run against a model.
module tb_reg_file_2r1w;

  localparam int WIDTH  = 16;
  localparam int DEPTH  = 6;
  localparam int ADDR_W = 3;
`ifdef RF_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic              clk, rst;
  logic              we, re_a, re_b, issue;
  logic [ADDR_W-1:0] waddr, raddr_a, raddr_b, issue_addr;
  logic [WIDTH-1:0]  wdata, dout_a, dout_b;
  logic              busy_a, busy_b;

  reg_file_2r1w #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .CLK(clk), .RST(rst), .WE(we), .WADDR(waddr), .WDATA(wdata),
    .RE_A(re_a), .RADDR_A(raddr_a), .DOUT_A(dout_a),
    .RE_B(re_b), .RADDR_B(raddr_b), .DOUT_B(dout_b),
    .ISSUE(issue), .ISSUE_ADDR(issue_addr), .BUSY_A(busy_a), .BUSY_B(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: register contents, busy set and the two output latches.
  logic [WIDTH-1:0] m_reg [8];
  bit               m_busy [8];
  logic [WIDTH-1:0] m_da, m_db;

  function automatic bit m_live(input int a);
    return (a < DEPTH) && !(ZR && a == 0);
  endfunction

  function automatic logic [WIDTH-1:0] m_read(input int a);
    if (!m_live(a)) return '0;
    if (we && int'(waddr) == a) return wdata;
    return m_reg[a];
  endfunction

  function automatic bit m_busy_out(input int a);
    return m_live(a) && m_busy[a] && !(we && int'(waddr) == a);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 8; i++) begin
      m_reg[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_da = '0;
    m_db = '0;
  endtask

  task automatic m_step();
    logic [WIDTH-1:0] na, nb;
    na = re_a ? m_read(int'(raddr_a)) : m_da;
    nb = re_b ? m_read(int'(raddr_b)) : m_db;
    if (we && m_live(int'(waddr))) begin
      m_reg[waddr]  = wdata;
      m_busy[waddr] = 1'b0;
    end
    if (issue && m_live(int'(issue_addr)))
      m_busy[issue_addr] = 1'b1;
    m_da = na;
    m_db = nb;
  endtask

  logic             got_ba, got_bb, exp_ba, exp_bb;
  logic [WIDTH-1:0] got_da, got_db;

  // Called right after a falling edge with inputs already driven.
  task automatic cyc();
    #1;
    got_ba = busy_a;
    got_bb = busy_b;
    exp_ba = m_busy_out(int'(raddr_a));
    exp_bb = m_busy_out(int'(raddr_b));
    @(posedge clk);
    m_step();
    #1;
    got_da = dout_a;
    got_db = dout_b;
    @(negedge clk);
  endtask

  task automatic idle();
    we = 0; waddr = '0; wdata = '0;
    re_a = 0; raddr_a = '0; re_b = 0; raddr_b = '0;
    issue = 0; issue_addr = '0;
  endtask

  typedef struct {
    logic             we;
    logic [2:0]       wa;
    logic [15:0]      wd;
    logic             rea;
    logic [2:0]       ra;
    logic             reb;
    logic [2:0]       rb;
    logic             iss;
    logic [2:0]       ia;
    logic [15:0]      eda, edb;
    logic             eba, ebb;
  } vec_t;

  function automatic vec_t mk(
    input logic w, input logic [2:0] wa, input logic [15:0] wd,
    input logic rea, input logic [2:0] ra, input logic reb, input logic [2:0] rb,
    input logic iss, input logic [2:0] ia,
    input logic [15:0] eda, input logic [15:0] edb, input logic eba, input logic ebb);
    vec_t v;
    v.we = w; v.wa = wa; v.wd = wd; v.rea = rea; v.ra = ra; v.reb = reb; v.rb = rb;
    v.iss = iss; v.ia = ia; v.eda = eda; v.edb = edb; v.eba = eba; v.ebb = ebb;
    return v;
  endfunction

  vec_t tbl [18];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = mk(1, 3, 16'hEFEF, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
    tbl[1]  = mk(0, 0, 16'h0000, 1, 3, 0, 0, 0, 0, 16'hEFEF, 16'h0000, 0, 0);
    tbl[2]  = mk(0, 0, 16'h0000, 0, 3, 0, 0, 0, 0, 16'hEFEF, 16'h0000, 0, 0);
    tbl[3]  = mk(0, 0, 16'h0000, 0, 3, 0, 0, 0, 0, 16'hEFEF, 16'h0000, 0, 0);
    tbl[4]  = mk(0, 0, 16'h0000, 0, 3, 0, 0, 0, 0, 16'hEFEF, 16'h0000, 0, 0);
    tbl[5]  = mk(1, 5, 16'h1111, 0, 3, 0, 0, 0, 0, 16'hEFEF, 16'h0000, 0, 0);
    tbl[6]  = mk(1, 5, 16'h1234, 1, 5, 1, 5, 0, 0, 16'h1234, 16'h1234, 0, 0);
    tbl[7]  = mk(0, 0, 16'h0000, 0, 2, 0, 0, 1, 2, 16'h1234, 16'h1234, 0, 0);
    tbl[8]  = mk(0, 0, 16'h0000, 0, 2, 0, 0, 0, 0, 16'h1234, 16'h1234, 1, 0);
    tbl[9]  = mk(1, 2, 16'h0202, 1, 2, 0, 0, 0, 0, 16'h0202, 16'h1234, 0, 0);
    tbl[10] = mk(0, 0, 16'h0000, 0, 2, 0, 0, 0, 0, 16'h0202, 16'h1234, 0, 0);
    tbl[11] = mk(1, 2, 16'h0303, 0, 2, 0, 0, 1, 2, 16'h0202, 16'h1234, 0, 0);
    tbl[12] = mk(0, 0, 16'h0000, 1, 2, 0, 0, 0, 0, 16'h0303, 16'h1234, 1, 0);
    tbl[13] = mk(1, 2, 16'h0404, 0, 0, 0, 4, 1, 4, 16'h0303, 16'h1234, 0, 0);
    tbl[14] = mk(0, 0, 16'h0000, 0, 2, 0, 4, 0, 0, 16'h0303, 16'h1234, 0, 1);
    tbl[15] = mk(1, 7, 16'hBEEF, 1, 7, 0, 4, 0, 0, 16'h0000, 16'h1234, 0, 1);
    tbl[16] = mk(0, 0, 16'h0000, 1, 7, 1, 3, 1, 7, 16'h0000, 16'hEFEF, 0, 0);
    tbl[17] = mk(0, 0, 16'h0000, 0, 7, 1, 5, 0, 0, 16'h0000, 16'h1234, 0, 0);

    idle();
    rst = 1'b1;
    m_reset();
    repeat (2) @(negedge clk);
    chk("rst_dout_a", 32'(dout_a), 32'h0);
    chk("rst_dout_b", 32'(dout_b), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      we = tbl[i].we; waddr = tbl[i].wa; wdata = tbl[i].wd;
      re_a = tbl[i].rea; raddr_a = tbl[i].ra;
      re_b = tbl[i].reb; raddr_b = tbl[i].rb;
      issue = tbl[i].iss; issue_addr = tbl[i].ia;
      cyc();
      chk($sformatf("tbl%0d_busy_a", i), 32'(got_ba), 32'(tbl[i].eba));
      chk($sformatf("tbl%0d_busy_b", i), 32'(got_bb), 32'(tbl[i].ebb));
      chk($sformatf("tbl%0d_dout_a", i), 32'(got_da), 32'(tbl[i].eda));
      chk($sformatf("tbl%0d_dout_b", i), 32'(got_db), 32'(tbl[i].edb));
    end

    // Asynchronous reset between edges while registers hold data and reg 4 is busy.
    idle();
    raddr_a = 3'd3;
    raddr_b = 3'd4;
    #1;
    chk("pre_rst_busy_b", 32'(busy_b), 32'h1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_dout_a", 32'(dout_a), 32'h0);
    chk("async_rst_dout_b", 32'(dout_b), 32'h0);
    chk("async_rst_busy_b", 32'(busy_b), 32'h0);
    m_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < 8; a++) begin
      idle();
      re_a = 1; raddr_a = 3'(a);
      re_b = 1; raddr_b = 3'(7 - a);
      cyc();
      chk($sformatf("post_rst_rd%0d_a", a), 32'(got_da), 32'h0);
      chk($sformatf("post_rst_rd%0d_b", a), 32'(got_db), 32'h0);
      chk($sformatf("post_rst_busy%0d", a), 32'(got_ba), 32'h0);
    end

    // Register 0 handling.
    idle(); we = 1; waddr = 3'd0; wdata = 16'hFFFF; cyc();
    idle(); re_a = 1; raddr_a = 3'd0; cyc();
    chk("zero_rd", 32'(got_da), ZR ? 32'h0 : 32'hFFFF);
    idle(); issue = 1; issue_addr = 3'd0; cyc();
    idle(); raddr_a = 3'd0; cyc();
    chk("zero_busy", 32'(got_ba), ZR ? 32'h0 : 32'h1);
    idle(); we = 1; waddr = 3'd0; wdata = 16'hAAAA; re_a = 1; raddr_a = 3'd0; cyc();
    chk("zero_bypass", 32'(got_da), ZR ? 32'h0 : 32'hAAAA);
    chk("zero_bypass_busy", 32'(got_ba), 32'h0);

    // Randomized traffic checked against the model.
    for (int n = 0; n < 400; n++) begin
      we         = ($urandom_range(0, 1) == 1);
      waddr      = 3'($urandom_range(0, 7));
      wdata      = 16'($urandom);
      re_a       = ($urandom_range(0, 3) != 0);
      raddr_a    = ($urandom_range(0, 3) == 0) ? waddr : 3'($urandom_range(0, 7));
      re_b       = ($urandom_range(0, 3) != 0);
      raddr_b    = ($urandom_range(0, 3) == 0) ? raddr_a : 3'($urandom_range(0, 7));
      issue      = ($urandom_range(0, 2) == 0);
      issue_addr = ($urandom_range(0, 3) == 0) ? waddr : 3'($urandom_range(0, 7));
      cyc();
      chk($sformatf("rnd%0d_busy_a", n), 32'(got_ba), 32'(exp_ba));
      chk($sformatf("rnd%0d_busy_b", n), 32'(got_bb), 32'(exp_bb));
      chk($sformatf("rnd%0d_dout_a", n), 32'(got_da), 32'(m_da));
      chk($sformatf("rnd%0d_dout_b", n), 32'(got_db), 32'(m_db));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- Parametrised multi-port register file. Successor to the single 16-bit load/hold register.
- Sits between decode and execute in the 16-bit RISC datapath.
- One synchronous write port and two registered read ports, with write-to-read bypass.
- Per-register busy scoreboard so decode can stall on in-flight destinations.

Parameters:
- WIDTH, 16, data width of each register.
- DEPTH, 8, number of registers.
- ADDR_W, 3, address width; DEPTH must not exceed 2**ADDR_W.

Ports:
- CLK  input  1  clock, all state changes on rising edge.
- RST  input  1  asynchronous, active-high reset.
- WE  input  1  write enable.
- WADDR  input  ADDR_W  write address.
- WDATA  input  WIDTH  write data.
- RE_A  input  1  read enable, port A.
- RADDR_A  input  ADDR_W  read address, port A.
- DOUT_A  output  WIDTH  registered read data, port A.
- RE_B  input  1  read enable, port B.
- RADDR_B  input  ADDR_W  read address, port B.
- DOUT_B  output  WIDTH  registered read data, port B.
- ISSUE  input  1  mark destination ISSUE_ADDR busy.
- ISSUE_ADDR  input  ADDR_W  destination register of the issuing instruction.
- BUSY_A  output  1  combinational busy flag of RADDR_A.
- BUSY_B  output  1  combinational busy flag of RADDR_B.

Behaviour:
- Reset: RST high asynchronously clears all registers, DOUT_A, DOUT_B and all busy bits to 0, including mid-operation. The first edge after RST falls behaves as a normal cycle.
- Write:
  - At a rising edge with WE=1 and WADDR < DEPTH: reg[WADDR] <= WDATA and busy[WADDR] <= 0.
  - WADDR >= DEPTH: write ignored.
- Read, per port, with latency 1:
  - At a rising edge with RE_x=1: DOUT_x <= selected value.
  - Selected value is WDATA if WE=1 and WADDR==RADDR_x (write-through bypass). Otherwise it is reg[RADDR_x].
  - RADDR_x >= DEPTH returns 0.
  - RE_x=0: DOUT_x holds its previous value.
- Both ports reading the same address in the same cycle return identical data.
- Scoreboard:
  - At a rising edge with ISSUE=1 and ISSUE_ADDR < DEPTH: busy[ISSUE_ADDR] <= 1.
  - ISSUE and WE to the same address in the same cycle: set wins, busy=1. This reflects a new instruction overwriting the pending one.
  - ISSUE and WE to different addresses: both take effect.
- BUSY_x = busy[RADDR_x] & ~(WE & WADDR==RADDR_x).
  - The in-cycle writeback masks busy, consistent with the bypass.
  - RADDR_x >= DEPTH gives BUSY_x=0.
- No other state. No X propagation permitted on any output after reset.

Optional Feature:
- Macro: RF_ZERO_REG_EN.
- When defined, register 0 is hardwired zero:
  - Writes to address 0 are ignored.
  - Reads of address 0 return 0, including when bypass would apply.
  - ISSUE to address 0 never sets busy, and BUSY_x for address 0 is always 0.
- When undefined, register 0 is an ordinary register.

Test Plan:
- Reset: drive RST=1 mid-run with registers loaded, then release -> DOUT_A=DOUT_B=16'h0000, BUSY_A=BUSY_B=0, and a read of every address returns 16'h0000.
- Write/read latency: WE=1, WADDR=3, WDATA=16'hEFEF; next cycle RE_A=1, RADDR_A=3 -> DOUT_A=16'hEFEF one edge later. Then RE_A=0 for 3 cycles -> DOUT_A holds 16'hEFEF.
- Bypass: same cycle WE=1, WADDR=5, WDATA=16'h1234 and RE_A=RE_B=1, RADDR_A=RADDR_B=5 -> after the edge DOUT_A=DOUT_B=16'h1234, not the old reg[5].
- Scoreboard:
  - ISSUE=1, ISSUE_ADDR=2 -> BUSY_A=1 when RADDR_A=2.
  - Later WE=1, WADDR=2 -> BUSY_A=0 combinationally during that cycle and stays 0 after.
  - Same-cycle ISSUE and WE on address 2 -> busy remains 1.
- Zero register with RF_ZERO_REG_EN defined: WE=1, WADDR=0, WDATA=16'hFFFF; read address 0 -> DOUT_A=16'h0000; ISSUE to 0 -> BUSY_A=0. Without the macro -> DOUT_A=16'hFFFF.
- Out of range with DEPTH=6, ADDR_W=3: write to address 7, then read address 7 -> DOUT_A=16'h0000, no other register modified, BUSY_A=0.
